// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch: one instruction in flight, PC update from decoder pcsel after execute.
// Latency: 1 idle cycle after reset, >=1 fetch cycle (waits on imem_ack), >=1 exec cycle (waits on exec_done).
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        nReset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  pcsel,
   input  logic        br_taken,
   input  logic [31:0] jalr_target,
   input  logic        exec_done,
   output logic        misalign
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

   state_t      state, state_nx;
   logic        instr_ld, pc_ld, mis_set;
   logic [31:0] imm_b, imm_j, pc_nx;

   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign pc_plus4    = pc + 32'd4;
   assign imem_addr   = pc;
   assign imem_req    = (state == FETCH);
   assign instr_valid = (state == EXEC);
   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];

   always_comb begin
      pc_nx = pc_plus4;
      case (pcsel)
         2'b01:   pc_nx = {jalr_target[31:1], 1'b0};
         2'b10:   pc_nx = br_taken ? (pc + imm_b) : pc_plus4;
         2'b11:   pc_nx = pc + imm_j;
         default: pc_nx = pc_plus4;
      endcase
   end

   always_comb begin
      state_nx = state;
      instr_ld = 1'b0;
      pc_ld    = 1'b0;
      mis_set  = 1'b0;
      case (state)
         IDLE:  state_nx = FETCH;
         FETCH: begin
            if (imem_ack) begin
               instr_ld = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC: begin
            if (exec_done) begin
               // A misaligned target freezes the PC at the offending instruction.
               if (pc_nx[1:0] != 2'b00) begin
                  mis_set  = 1'b1;
                  state_nx = HALT;
               end else begin
                  pc_ld    = 1'b1;
                  state_nx = FETCH;
               end
            end
         end
         HALT:    state_nx = HALT;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         instr    <= NOP_INSTR;
         misalign <= 1'b0;
      end else begin
         state <= state_nx;
         if (instr_ld) instr    <= imem_rdata;
         if (pc_ld)    pc       <= pc_nx;
         if (mis_set)  misalign <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed PC-flow scenarios followed by randomized instruction streams
// checked against an arithmetic next-PC model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_W    = 32'h0000_0013;
   localparam logic [31:0] JALR_W   = 32'h0000_80E7;

   logic        clock = 1'b0;
   logic        nReset, imem_req, imem_ack, instr_valid, br_taken, exec_done, misalign;
   logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, jalr_target;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [1:0]  pcsel;

   int          npass = 0;
   int          ncheck = 0;
   logic [31:0] exp_pc;
   bit          halted;

   fetch_unit dut (
      .clock(clock), .nReset(nReset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
      .funct3(funct3), .funct7(funct7), .instr_valid(instr_valid), .pc(pc),
      .pc_plus4(pc_plus4), .pcsel(pcsel), .br_taken(br_taken), .jalr_target(jalr_target),
      .exec_done(exec_done), .misalign(misalign)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncheck++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference next PC from the immediate definitions, using plain integer arithmetic.
   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                              input logic [1:0] sel, input bit bt,
                                              input logic [31:0] jt);
      int ib, ij;
      ib = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - (w[31] ? 4096 : 0);
      ij = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
           - (w[31] ? (1 << 20) : 0);
      case (sel)
         2'd0:    return p + 32'd4;
         2'd1:    return jt & ~32'd1;
         2'd2:    return bt ? p + 32'(ib) : p + 32'd4;
         default: return p + 32'(ij);
      endcase
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6F};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm);
      return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'h63};
   endfunction

   task automatic do_reset;
      @(negedge clock);
      nReset = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
      #1;
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc",    pc, RESET_PC);
      chk("rst_instr", instr, NOP_W);
      chk("rst_mis",   32'(misalign), 32'd0);
      @(negedge clock);
      nReset = 1'b1; exp_pc = RESET_PC; halted = 1'b0;
      #1;
      chk("idle_req", 32'(imem_req), 32'd0);
   endtask

   task automatic do_instr(input logic [31:0] word, input int ack_dly, input int exe_dly,
                           input logic [1:0] sel, input bit bt, input logic [31:0] jt);
      logic [31:0] prev, nx;
      int n;
      n = 0;
      @(negedge clock);
      while (!imem_req && n < 4) begin
         @(negedge clock);
         n++;
      end
      chk("fetch_req",  32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, exp_pc);
      prev = instr;
      for (int i = 0; i < ack_dly; i++) begin
         imem_ack = 1'b0; exec_done = 1'($urandom); imem_rdata = $urandom;
         @(negedge clock);
         chk("wait_req",   32'(imem_req), 32'd1);
         chk("wait_addr",  imem_addr, exp_pc);
         chk("wait_instr", instr, prev);
         chk("wait_valid", 32'(instr_valid), 32'd0);
      end
      exec_done = 1'b0; imem_ack = 1'b1; imem_rdata = word;
      @(negedge clock);
      imem_ack = 1'b0;
      chk("exec_valid",  32'(instr_valid), 32'd1);
      chk("exec_req",    32'(imem_req), 32'd0);
      chk("exec_instr",  instr, word);
      chk("exec_opcode", 32'(opcode), 32'(word[6:0]));
      chk("exec_funct3", 32'(funct3), 32'(word[14:12]));
      chk("exec_funct7", 32'(funct7), 32'(word[31:25]));
      chk("exec_pc",     pc, exp_pc);
      chk("exec_pc4",    pc_plus4, exp_pc + 32'd4);
      for (int i = 0; i < exe_dly; i++) begin
         imem_ack = 1'($urandom); imem_rdata = $urandom; pcsel = 2'($urandom);
         br_taken = 1'($urandom); jalr_target = $urandom;
         @(negedge clock);
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_instr", instr, word);
         chk("hold_pc",    pc, exp_pc);
      end
      imem_ack = 1'b0; exec_done = 1'b1; pcsel = sel; br_taken = bt; jalr_target = jt;
      @(negedge clock);
      exec_done = 1'b0; pcsel = 2'($urandom); br_taken = 1'($urandom); jalr_target = $urandom;
      nx = model_next(exp_pc, word, sel, bt, jt);
      if (nx[1:0] != 2'b00) begin
         chk("mis_flag", 32'(misalign), 32'd1);
         chk("mis_pc",   pc, exp_pc);
         halted = 1'b1;
         for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            @(negedge clock);
            chk("halt_req",   32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_mis",   32'(misalign), 32'd1);
         end
         imem_ack = 1'b0;
      end else begin
         exp_pc = nx;
         chk("next_req",  32'(imem_req), 32'd1);
         chk("next_addr", imem_addr, nx);
         chk("next_mis",  32'(misalign), 32'd0);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] w, jt;
      logic [1:0]  sel;
      nReset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
      pcsel = 2'd0; br_taken = 1'b0; jalr_target = '0; exp_pc = RESET_PC; halted = 1'b0;

      do_reset();
      do_instr(32'h0050_0093, 0, 0, 2'd0, 1'b0, 32'd0);
      do_instr(enc_j(32'h0000_00FC), 3, 1, 2'd3, 1'b0, 32'd0);
      do_instr(enc_b(32'hFFFF_FFF8), 0, 0, 2'd2, 1'b1, 32'd0);
      do_instr(enc_j(32'h0000_0008), 1, 0, 2'd3, 1'b0, 32'd0);
      do_instr(enc_b(32'hFFFF_FFF8), 0, 2, 2'd2, 1'b0, 32'd0);
      do_instr(enc_j(32'hFFFF_FF3C), 0, 0, 2'd3, 1'b0, 32'd0);
      do_instr(enc_j(32'h0000_0020), 0, 0, 2'd3, 1'b0, 32'd0);
      do_instr(JALR_W, 0, 0, 2'd1, 1'b0, 32'h0000_0201);
      do_instr(JALR_W, 0, 0, 2'd1, 1'b0, 32'h0000_0202);
      do_reset();
      do_instr(JALR_W, 0, 0, 2'd1, 1'b0, 32'hFFFF_FFFC);
      do_instr(NOP_W, 0, 0, 2'd0, 1'b0, 32'd0);

      // Reset arriving while a fetch is waiting on its ack must drop the request at once.
      @(negedge clock);
      chk("pend_req", 32'(imem_req), 32'd1);
      #2 nReset = 1'b0;
      #1;
      chk("async_req",   32'(imem_req), 32'd0);
      chk("async_valid", 32'(instr_valid), 32'd0);
      chk("async_pc",    pc, RESET_PC);
      @(negedge clock);
      nReset = 1'b1; exp_pc = RESET_PC;

      for (int k = 0; k < 300; k++) begin
         w   = $urandom;
         sel = 2'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            w[8]  = 1'b0;
            w[21] = 1'b0;
         end
         jt = $urandom;
         if ($urandom_range(0, 7) != 0) jt[1] = 1'b0;
         do_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), sel,
                  1'($urandom), jt);
         if (halted) do_reset();
      end

      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end

endmodule
